// File: rtl/bcd_counter_chain.sv
// bcd_counter_chain: cascaded BCD up/down counter with a prescaled enable,
// synchronous clamped load, and registered step/carry pulses. Digit 0 feeds
// the seven-segment decoder.
// Build option: define BCD_COUNTER_SATURATE_EN to hold the value at the
// terminal count (all 9s up / all 0s down) instead of wrapping. In both
// builds step and carry still pulse on the attempted overflow.

// One BCD digit: next value, ripple-enable to the next digit, clamped load.
module bcd_digit (
  input  logic       up,
  input  logic       cin,
  input  logic [3:0] d,
  input  logic [3:0] lv,
  output logic       cout,
  output logic [3:0] nd,
  output logic [3:0] ld
);
  logic at9, at0;
  assign at9 = (d == 4'd9);
  assign at0 = (d == 4'd0);

  // This digit only moves when every lower digit is at its rollover value.
  assign cout = cin & (up ? at9 : at0);

  // Next digit value on a step; values 9->0 and 0->9 roll over, so A-F can
  // never be produced.
  always_comb begin
    nd = d;
    if (cin) begin
      if (up) nd = at9 ? 4'd0 : d + 4'd1;
      else    nd = at0 ? 4'd9 : d - 4'd1;
    end
  end

  // Loaded nibbles above 9 are clamped so digits stay BCD.
  assign ld = (lv > 4'd9) ? 4'd9 : lv;
endmodule

module bcd_counter_chain #(
  parameter int NUM_DIGITS = 2,
  parameter int PRESCALE   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    step,
  output logic                    carry
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  logic [NUM_DIGITS-1:0][3:0] dq, dnext, dload, lvv;
  logic [NUM_DIGITS:0]        chain;
  logic [PW-1:0]              pcnt;
  logic                       term;
  logic                       tick;

  assign lvv      = load_val;
  assign digits   = dq;
  assign chain[0] = 1'b1;
  // All digits at their rollover value: the count is at its terminal value.
  assign term     = chain[NUM_DIGITS];
  assign tick     = en & (pcnt == PLAST);

  genvar i;
  generate
    for (i = 0; i < NUM_DIGITS; i++) begin : g_dig
      bcd_digit u_dig (
        .up   (up),
        .cin  (chain[i]),
        .d    (dq[i]),
        .lv   (lvv[i]),
        .cout (chain[i+1]),
        .nd   (dnext[i]),
        .ld   (dload[i])
      );
    end
  endgenerate

  // Load beats enable; a step updates digits and pulses step/carry on the
  // same edge. Direction is sampled only at the step edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dq    <= '0;
      pcnt  <= '0;
      step  <= 1'b0;
      carry <= 1'b0;
    end else if (load) begin
      dq    <= dload;
      pcnt  <= '0;
      step  <= 1'b0;
      carry <= 1'b0;
    end else if (tick) begin
      pcnt  <= '0;
      step  <= 1'b1;
      carry <= term;
`ifdef BCD_COUNTER_SATURATE_EN
      if (!term) dq <= dnext;
`else
      dq    <= dnext;
`endif
    end else begin
      if (en) pcnt <= pcnt + PW'(1);
      step  <= 1'b0;
      carry <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bcd_counter_chain.sv
// Bench for bcd_counter_chain: two instances (PRESCALE=1 and PRESCALE=3)
// share stimulus; each is compared every cycle against an integer-valued
// reference model, plus directed checks from the behavioural scenarios.
module tb_bcd_counter_chain;
  localparam int ND  = 2;
  localparam int MAX = 99;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0, up = 1'b1, load = 1'b0;
  logic [4*ND-1:0] load_val = '0;
  logic [4*ND-1:0] dig1, dig3;
  logic          st1, cy1, st3, cy3;

  int ntests = 0, nfail = 0;
  int v1 = 0, pc1 = 0, v3 = 0, pc3 = 0;
  bit ms1 = 0, mc1 = 0, ms3 = 0, mc3 = 0;

  always #5 clk = ~clk;

  bcd_counter_chain #(.NUM_DIGITS(ND), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .digits(dig1), .step(st1), .carry(cy1));

  bcd_counter_chain #(.NUM_DIGITS(ND), .PRESCALE(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .digits(dig3), .step(st3), .carry(cy3));

  function automatic logic [4*ND-1:0] to_bcd(input int v);
    logic [4*ND-1:0] r;
    int p;
    r = '0;
    p = v;
    for (int k = 0; k < ND; k++) begin
      r[4*k +: 4] = 4'(p % 10);
      p = p / 10;
    end
    return r;
  endfunction

  function automatic int load_int(input logic [4*ND-1:0] lv);
    int r, w, n;
    r = 0;
    w = 1;
    for (int k = 0; k < ND; k++) begin
      n = int'(lv[4*k +: 4]);
      if (n > 9) n = 9;
      r = r + n * w;
      w = w * 10;
    end
    return r;
  endfunction

  task automatic model(input int ps, inout int v, inout int pc,
                       output bit s, output bit c);
    bit t;
    s = 0;
    c = 0;
    if (rst) begin
      v = 0; pc = 0;
    end else if (load) begin
      v = load_int(load_val); pc = 0;
    end else if (en) begin
      pc = pc + 1;
      if (pc == ps) begin
        pc = 0;
        s = 1;
        t = up ? (v == MAX) : (v == 0);
        c = t;
`ifdef BCD_COUNTER_SATURATE_EN
        if (!t) v = up ? v + 1 : v - 1;
`else
        if (up) v = t ? 0 : v + 1;
        else    v = t ? MAX : v - 1;
`endif
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("dig_p1",   32'(dig1), 32'(to_bcd(v1)));
    chk("step_p1",  32'(st1),  32'(ms1));
    chk("carry_p1", 32'(cy1),  32'(mc1));
    chk("dig_p3",   32'(dig3), 32'(to_bcd(v3)));
    chk("step_p3",  32'(st3),  32'(ms3));
    chk("carry_p3", 32'(cy3),  32'(mc3));
  endtask

  // One rising edge: advance both models with the inputs present at the
  // edge, then sample the DUTs 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model(1, v1, pc1, ms1, mc1);
    model(3, v3, pc3, ms3, mc3);
    #1;
    check_all();
  endtask

  task automatic do_load(input logic [4*ND-1:0] lv);
    load = 1; load_val = lv;
    tick();
    load = 0;
  endtask

  initial begin
    // Reset held
    rst = 1;
    tick(); tick();
    chk("rst_dig", 32'(dig1), 32'h0);
    rst = 0;

    // Count up 15 edges from 0
    en = 1; up = 1;
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("step_every_edge", 32'(st1), 32'h1);
    end
    chk("count15", 32'(dig1), 32'h15);
    chk("count15_p3", 32'(dig3), 32'h05);

    // Wrap up from 98
    do_load(8'h98);
    tick();
    chk("to99", 32'(dig1), 32'h99);
    chk("to99_carry", 32'(cy1), 32'h0);
    tick();
`ifdef BCD_COUNTER_SATURATE_EN
    chk("wrap_hold", 32'(dig1), 32'h99);
`else
    chk("wrap", 32'(dig1), 32'h00);
`endif
    chk("wrap_carry", 32'(cy1), 32'h1);
    tick();
    chk("carry_one_edge", 32'(cy1), 32'h0);

    // Down borrow
    up = 0;
    do_load(8'h10);
    tick();
    chk("borrow", 32'(dig1), 32'h09);
    do_load(8'h00);
    tick();
`ifdef BCD_COUNTER_SATURATE_EN
    chk("down_hold", 32'(dig1), 32'h00);
`else
    chk("down_wrap", 32'(dig1), 32'h99);
`endif
    chk("down_carry", 32'(cy1), 32'h1);

    // Prescale: 9 enabled edges from 0 -> 3 steps
    up = 1;
    do_load(8'h00);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("p3_step_pos", 32'(st3), 32'((k % 3) == 0));
    end
    chk("p3_nine", 32'(dig3), 32'h03);
    // en low for two cycles mid-run stretches the next step
    tick();
    en = 0; tick(); tick();
    en = 1;
    tick();
    chk("p3_stretch_nostep", 32'(st3), 32'h0);
    tick();
    chk("p3_stretch_step", 32'(st3), 32'h1);
    chk("p3_stretch_val", 32'(dig3), 32'h04);

    // Load priority and clamp at pcnt == PRESCALE-1
    tick(); tick();
    do_load(8'hAF);
    chk("clamp", 32'(dig3), 32'h99);
    chk("load_nostep", 32'(st3), 32'h0);
    tick(); tick();
    chk("post_load_wait", 32'(st3), 32'h0);
    tick();
    chk("post_load_step", 32'(st3), 32'h1);

    // Asynchronous reset mid-count
    do_load(8'h37);
    tick();
    #2 rst = 1;
    #1;
    v1 = 0; pc1 = 0; v3 = 0; pc3 = 0;
    ms1 = 0; mc1 = 0; ms3 = 0; mc3 = 0;
    chk("async_rst_dig", 32'(dig1), 32'h00);
    chk("async_rst_step", 32'(st1), 32'h0);
    check_all();
    tick();
    rst = 0;

    // Randomized run
    for (int k = 0; k < 400; k++) begin
      en       = ($urandom_range(0, 3) != 0);
      up       = $urandom_range(0, 1) != 0;
      load     = ($urandom_range(0, 9) == 0);
      load_val = 8'($urandom);
      if ($urandom_range(0, 3) == 0) load_val = ($urandom_range(0, 1) != 0) ? 8'h99 : 8'h00;
      rst      = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 0; load = 0; en = 0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
